board_io_frontend: RTL
======================

BOARD_IO_FRONTEND -- requirements
Module: board_io_frontend

Interface
REQ-001 Parameter NUM_KEYS, default 4: number of active-low pushbuttons handled.
REQ-002 Parameter NUM_SW, default 10: number of slide switches synchronised.
REQ-003 Parameter NUM_HEX, default 6: number of seven-segment digits driven.
REQ-004 Parameter DEBOUNCE_CYCLES, default 500000: cycles a new key level must hold before acceptance; minimum 2.
REQ-005 Parameter BLINK_CYCLES, default 12500000: cycles per blink half-period; minimum 1.
REQ-006 The design SHALL have one clock and a synchronous, active-high reset: CLOCK_50 input 1: 50 MHz board clock; RESET input 1: synchronous active-high reset.
REQ-007 KEY  input  NUM_KEYS  raw pushbuttons, low = pressed, asynchronous.
REQ-008 SW  input  NUM_SW  raw switches, asynchronous.
REQ-009 key_down  output  NUM_KEYS  debounced level, 1 = pressed.
REQ-010 key_press  output  NUM_KEYS  one-cycle pulse on accepted press.
REQ-011 sw_sync  output  NUM_SW  synchronised switch levels.
REQ-012 hex_value  input  4*NUM_HEX  nibble per digit; digit i = bits [4i+3:4i].
REQ-013 hex_blank  input  NUM_HEX  1 = digit dark.
REQ-014 hex_blink  input  NUM_HEX  1 = digit flashes with blink phase.
REQ-015 HEX  output  7*NUM_HEX  active-low segments; digit i = bits [7i+6:7i], bit 0 = segment a ... bit 6 = segment g.
REQ-016 led_in  input  NUM_SW  requested LED pattern; LEDR  output  NUM_SW  registered LED drive.

Function
REQ-017 KEY and SW SHALL each pass through a 2-flop synchroniser; KEY is inverted after synchronisation (pressed = 1).
REQ-018 sw_sync SHALL equal SW delayed by exactly 2 cycles.
REQ-019 Per key, a counter SHALL clear when the synchronised level equals key_down, else increment.
REQ-020 When the counter reaches DEBOUNCE_CYCLES-1 with the level still differing, key_down SHALL take the new level and the counter SHALL clear; a level change is therefore accepted after DEBOUNCE_CYCLES consecutive differing cycles.
REQ-021 Any glitch shorter than DEBOUNCE_CYCLES SHALL leave key_down unchanged and restart the count.
REQ-022 key_press[i] SHALL be 1 for exactly the cycle in which key_down[i] goes 0->1; release produces no pulse.
REQ-023 Keys SHALL debounce independently; simultaneous presses yield simultaneous pulses.
REQ-024 A free-running blink counter SHALL count 0..BLINK_CYCLES-1 and wrap; blink_phase toggles on each wrap.
REQ-025 Digit i SHALL be dark (7'h7F) when hex_blank[i], or when hex_blink[i] and blink_phase = 1; otherwise it shows the hex glyph of its nibble. hex_blank has priority.
REQ-026 Glyphs, active-low: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
REQ-027 HEX and LEDR SHALL be registered, with 1-cycle latency from hex_value/hex_blank/hex_blink/led_in/blink_phase.

Reset
REQ-028 While RESET = 1 at a clock edge, all synchroniser flops, key_down, key_press, debounce counters, sw_sync, blink counter, blink_phase and LEDR SHALL clear to 0, and every HEX digit SHALL go to 7'h7F.
REQ-029 Reset asserted mid-debounce SHALL discard the partial count; no key_press is generated by reset entry or exit.
REQ-030 A key held through reset SHALL be accepted DEBOUNCE_CYCLES+2 cycles after RESET falls.

Structure
REQ-031 The glyph table, blank code 7'h7F, and the width helper for counter sizing ($clog2) SHALL live in shared package board_io_pkg.
REQ-032 Per-key synchroniser, debounce and edge logic SHALL be sub-module key_debouncer, instantiated NUM_KEYS times by generate.
REQ-033 Debounce and blink counters SHALL be sized $clog2 of their parameter; no other arithmetic is required.

Verification (DEBOUNCE_CYCLES=4, BLINK_CYCLES=8, NUM_HEX=6)
REQ-034 Bench: KEY[0] held low 10 cycles -> key_down[0] rises 6 cycles after the KEY edge; key_press[0] is high that single cycle.
REQ-035 Bench: KEY[1] low 3 cycles, high 1 cycle, low 3 cycles -> key_down[1] stays 0 and no pulse occurs.
REQ-036 Bench: hex_value=24'h0123AF, blank=0, blink=0 -> next cycle HEX digits 0..5 = 0E,08,30,24,79,40.
REQ-037 Bench: hex_blink=6'b000001, hex_blank=6'b000010 -> digit0 alternates glyph/7F every 8 cycles; digit1 is constant 7F.
REQ-038 Bench: RESET pulsed while KEY[2] is mid-debounce (count 2) -> all outputs at reset values, HEX=7F x6, no key_press; key_down[2] rises 6 cycles after RESET falls.
REQ-039 Bench: SW=10'h2A5 -> sw_sync=10'h2A5 exactly 2 cycles later; led_in=10'h155 -> LEDR=10'h155 one cycle later.

Source files
------------

// File: rtl/board_io_pkg.sv
// board_io_pkg: shared seven-segment glyph table, blank code and counter width helper
package board_io_pkg;
    localparam logic [6:0] HEX_BLANK = 7'h7F;
    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/key_debouncer.sv
// key_debouncer: one active-low key -> 2-flop sync, debounced level key_down, press pulse key_press
module key_debouncer import board_io_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic key_down,
    output logic key_press
);
    localparam int CW = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    logic s1_q, s1_d, s2_q, s2_d, down_q, down_d, press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        // inverting ahead of the first flop keeps cleared sync flops meaning "released"
        s1_d = ~key_n;
        s2_d = s1_q;
        cnt_d = (s2_q == down_q || cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        down_d = (s2_q != down_q && cnt_q == CNT_MAX) ? s2_q : down_q;
        press_d = down_d & ~down_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            cnt_q <= '0;
            down_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            cnt_q <= cnt_d;
            down_q <= down_d;
            press_q <= press_d;
        end
    end
    assign key_down = down_q;
    assign key_press = press_q;
endmodule

// File: rtl/board_io_frontend.sv
// board_io_frontend: debounced keys, synchronised switches, blinking hex digits, registered LEDs
module board_io_frontend import board_io_pkg::*; #(
    parameter int NUM_KEYS = 4,
    parameter int NUM_SW = 10,
    parameter int NUM_HEX = 6,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BLINK_CYCLES = 12500000
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET,
    input  logic [NUM_KEYS-1:0]   KEY,
    input  logic [NUM_SW-1:0]     SW,
    output logic [NUM_KEYS-1:0]   key_down,
    output logic [NUM_KEYS-1:0]   key_press,
    output logic [NUM_SW-1:0]     sw_sync,
    input  logic [4*NUM_HEX-1:0]  hex_value,
    input  logic [NUM_HEX-1:0]    hex_blank,
    input  logic [NUM_HEX-1:0]    hex_blink,
    output logic [7*NUM_HEX-1:0]  HEX,
    input  logic [NUM_SW-1:0]     led_in,
    output logic [NUM_SW-1:0]     LEDR
);
    localparam int BW = cnt_w(BLINK_CYCLES);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_CYCLES - 1);
    logic [NUM_SW-1:0] sw1_q, sw1_d, sw2_q, sw2_d, led_q, led_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic blink_q, blink_d;
    logic [7*NUM_HEX-1:0] hex_q, hex_d;
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk(CLOCK_50),
            .rst(RESET),
            .key_n(KEY[k]),
            .key_down(key_down[k]),
            .key_press(key_press[k])
        );
    end
    always_comb begin
        sw1_d = SW;
        sw2_d = sw1_q;
        led_d = led_in;
        bcnt_d = (bcnt_q == BLINK_MAX) ? '0 : bcnt_q + 1'b1;
        blink_d = (bcnt_q == BLINK_MAX) ? ~blink_q : blink_q;
        hex_d = '0;
        for (int i = 0; i < NUM_HEX; i++)
            hex_d[7*i +: 7] = (hex_blank[i] || (hex_blink[i] && blink_q)) ? HEX_BLANK : HEX_GLYPH[hex_value[4*i +: 4]];
    end
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            sw1_q <= '0;
            sw2_q <= '0;
            led_q <= '0;
            bcnt_q <= '0;
            blink_q <= 1'b0;
            hex_q <= {NUM_HEX{HEX_BLANK}};
        end else begin
            sw1_q <= sw1_d;
            sw2_q <= sw2_d;
            led_q <= led_d;
            bcnt_q <= bcnt_d;
            blink_q <= blink_d;
            hex_q <= hex_d;
        end
    end
    assign sw_sync = sw2_q;
    assign LEDR = led_q;
    assign HEX = hex_q;
endmodule
